// File: rtl/ds_pixel_packer_if.sv
// ds_pixel_packer_if: packed-word output stream of the pixel packer.
//   m_data  : 32-bit word, earliest pixel in bits [7:0]
//   m_sof   : first word of a frame
//   m_eol   : word holds the last pixel of a line
//   m_eof   : last word of the frame
//   m_valid : head word valid
//   m_ready : consumer accepts head when m_valid & m_ready
interface ds_pixel_packer_if;
    logic [31:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic        m_valid;
    logic        m_ready;

    modport master (
        output m_data, m_sof, m_eol, m_eof, m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data, m_sof, m_eol, m_eof, m_valid,
        output m_ready
    );
endinterface

// File: rtl/ds_pixel_packer.sv
// ds_pixel_packer: tracks pixel position in the downsampled frame, packs four
// pixels per 32-bit word with sof/eol/eof tags and buffers words in a FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : 8-bit pixel, sampled when write_en = 1
//   write_en   : pixel-valid strobe
//   m          : output word stream (master side)
//   level      : FIFO occupancy in words
//   ovf        : sticky overflow flag (word dropped while full)
module ds_pixel_packer #(
    parameter int unsigned LINE_PIX    = 128,
    parameter int unsigned FRAME_LINES = 128,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               din,
    input  logic                     write_en,
    ds_pixel_packer_if.master        m,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);
    localparam int unsigned XW = $clog2(LINE_PIX);
    localparam int unsigned YW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 35;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [23:0]   lane_q, lane_d;
    logic          push_q, push_d;
    logic [EW-1:0] word_q, word_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] mem [DEPTH];

    logic          sof_c, eol_c, eof_c;
    logic          valid_c, pop_c, push_ok_c;
    logic [EW-1:0] head_c;

    // Tags are derived from the position of the pixel that completes the word.
    assign sof_c = (x_q == XW'(3)) && (y_q == '0);
    assign eol_c = (x_q == XW'(LINE_PIX - 1));
    assign eof_c = eol_c && (y_q == YW'(FRAME_LINES - 1));

    assign valid_c   = (level_q != '0);
    assign pop_c     = valid_c & m.m_ready;
    assign push_ok_c = push_q && ((level_q < LW'(DEPTH)) || pop_c);

    // Position counters, packing lanes and push stage next-state.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        lane_d = lane_q;
        push_d = 1'b0;
        word_d = word_q;
        if (write_en) begin
            if (x_q == XW'(LINE_PIX - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(FRAME_LINES - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            case (x_q[1:0])
                2'd0:    lane_d[7:0]   = din;
                2'd1:    lane_d[15:8]  = din;
                2'd2:    lane_d[23:16] = din;
                default: begin
                    push_d = 1'b1;
                    word_d = {eof_c, eol_c, sof_c, din, lane_q};
                end
            endcase
        end
    end

    // FIFO pointer/occupancy next-state; a refused push only raises ovf.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (push_q & ~push_ok_c);
        if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)     rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            lane_q   <= '0;
            push_q   <= 1'b0;
            word_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            lane_q   <= lane_d;
            push_q   <= push_d;
            word_q   <= word_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Word storage is not reset; the read mux is gated by valid instead.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr_q] <= word_q;
    end

    assign head_c    = valid_c ? mem[rd_ptr_q] : '0;
    assign m.m_data  = head_c[31:0];
    assign m.m_sof   = head_c[32];
    assign m.m_eol   = head_c[33];
    assign m.m_eof   = head_c[34];
    assign m.m_valid = valid_c;
    assign level     = level_q;
    assign ovf       = ovf_q;
endmodule
